// File: rtl/ifu_fetch_engine.sv
// Instruction fetch unit: one outstanding aligned fetch, local JAL following,
// backend redirect with flush, and a DEPTH-entry queue toward decode.
module ifu_fetch_engine #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              DEPTH    = 4,
  parameter int              MEM_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [XLEN-1:0]  req_addr,
  input  logic             resp_valid,
  input  logic [MEM_W-1:0] resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_inst,
  output logic             out_jal,
  output logic             out_fault
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high; valid never depends on ready. resp_valid has no ready and is
  // always accepted, so requests issue only when a queue slot is guaranteed.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_FAULT} state_t;

  state_t          state;
  logic            run;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [31:0]     inst_q [DEPTH];
  logic [DEPTH-1:0] jal_q;
  logic [DEPTH-1:0] fault_q;

  logic            not_full;
  logic            aligned;
  logic            push_resp;
  logic            push_fault;
  logic            push;
  logic            pop;
  logic [31:0]     resp_inst;
  logic            resp_jal;
  logic [XLEN-1:0] jal_off;

  assign not_full   = count < CW'(DEPTH);
  assign aligned    = fetch_pc[1:0] == 2'b00;
  assign req_addr   = {fetch_pc[XLEN-1:3], 3'b000};
  // run holds requests off until the first clock after reset release
  assign req_valid  = run && (state == S_REQ) && not_full && !redirect_valid && aligned;

  assign resp_inst  = fetch_pc[2] ? resp_data[63:32] : resp_data[31:0];
  assign resp_jal   = resp_inst[6:0] == 7'b1101111;
  assign jal_off    = {{(XLEN-21){resp_inst[31]}}, resp_inst[31], resp_inst[19:12],
                       resp_inst[20], resp_inst[30:21], 1'b0};

  assign push_resp  = (state == S_WAIT) && resp_valid && !redirect_valid;
  assign push_fault = run && (state == S_REQ) && !aligned && not_full && !redirect_valid;
  assign push       = push_resp || push_fault;
  assign pop        = out_valid && out_ready && !redirect_valid;

  assign out_valid  = count != '0;
  assign out_pc     = out_valid ? pc_q[head]    : '0;
  assign out_inst   = out_valid ? inst_q[head]  : '0;
  assign out_jal    = out_valid ? jal_q[head]   : 1'b0;
  assign out_fault  = out_valid ? fault_q[head] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        // a still-outstanding response must be swallowed before refetching
        if ((state == S_WAIT || state == S_DROP) && !resp_valid) state <= S_DROP;
        else                                                   state <= S_REQ;
      end else begin
        case (state)
          S_REQ: begin
            if (req_valid && req_ready) state <= S_WAIT;
            else if (push_fault)        state <= S_FAULT;
          end
          S_WAIT: begin
            if (resp_valid) begin
              fetch_pc <= resp_jal ? fetch_pc + jal_off : fetch_pc + XLEN'(4);
              state    <= S_REQ;
            end
          end
          S_DROP: begin
            if (resp_valid) state <= S_REQ;
          end
          default: state <= S_FAULT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= fetch_pc;
      inst_q[tail]  <= push_fault ? 32'h0 : resp_inst;
      jal_q[tail]   <= push_resp && resp_jal;
      fault_q[tail] <= push_fault;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_engine.sv
// Bench for ifu_fetch_engine: sparse memory with a known program, expected
// instruction stream from a PC-walk model, directed phases plus random traffic.
module tb_ifu_fetch_engine;
  localparam int          XLEN     = 64;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          EW       = 64 + 32 + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             redirect_valid = 1'b0;
  logic [XLEN-1:0]  redirect_pc = '0;
  logic             req_valid;
  logic             req_ready = 1'b0;
  logic [XLEN-1:0]  req_addr;
  logic             resp_valid = 1'b0;
  logic [63:0]      resp_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [31:0]      out_inst;
  logic             out_jal;
  logic             out_fault;

  ifu_fetch_engine #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_jal(out_jal), .out_fault(out_fault)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory and program model ----------------
  logic [63:0] mem [logic [63:0]];
  int          jal_tab [logic [63:0]];

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [63:0]   fpc;
  bit            halted, pending, stale, warm, first_fire;
  int            wait_cnt;
  logic [63:0]   pend_addr;
  int            lat_min = 1, lat_max = 1, ready_pct = 100;
  int            n_cmp = 0, n_bad = 0, n_pops = 0, n_redir = 0;
  bit            got_fault;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] plain_inst();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], 7'b0010011};
  endfunction

  function automatic logic [31:0] make_jal(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic write_slot(input logic [63:0] a, input bit is_jal, input int off);
    logic [63:0] aw, w;
    logic [31:0] inst;
    aw = {a[63:3], 3'b000};
    inst = is_jal ? make_jal(off) : plain_inst();
    if (is_jal) jal_tab[a] = off;
    else if (jal_tab.exists(a)) jal_tab.delete(a);
    w = mem[aw];
    if (a[2]) w[63:32] = inst; else w[31:0] = inst;
    mem[aw] = w;
  endtask

  task automatic fill_word(input logic [63:0] aw);
    int off;
    if (!mem.exists(aw)) begin
      mem[aw] = '0;
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          off = (int'($urandom_range(0, 16)) - 8) * 4;
          if ($urandom_range(0, 7) == 0) off += 2;
          write_slot(aw + 64'(s * 4), 1'b1, off);
        end else begin
          write_slot(aw + 64'(s * 4), 1'b0, 0);
        end
      end
    end
  endtask

  task automatic set_slot(input logic [63:0] a, input bit is_jal, input int off);
    fill_word({a[63:3], 3'b000});
    write_slot(a, is_jal, off);
  endtask

  task automatic model_reset();
    exp_q.delete();
    fpc = RESET_PC; halted = 0; pending = 0; stale = 0; warm = 0; first_fire = 1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // rmode: 0 none, 1 random, 2 on response, 3 while waiting, 4 forced
  task automatic step(input int rmode, input logic [63:0] rpc_in);
    bit deliver, redir, pop, fire, is_jal;
    logic [63:0] rpc, w, npc;
    logic [31:0] inst;
    logic [EW-1:0] e;
    @(negedge clk);
    deliver = 0;
    if (pending) begin
      wait_cnt--;
      if (wait_cnt == 0) deliver = 1;
    end
    resp_valid = deliver;
    if (deliver) begin
      fill_word(pend_addr);
      resp_data = mem[pend_addr];
    end else begin
      resp_data = {$urandom(), $urandom()};
    end
    rpc = rpc_in;
    case (rmode)
      1: begin
        redir = ($urandom_range(0, 29) == 0);
        rpc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4;
        if ($urandom_range(0, 7) == 0) rpc += 2;
      end
      2: redir = deliver;
      3: redir = pending && !deliver;
      4: redir = 1;
      default: redir = 0;
    endcase
    redirect_valid = redir;
    redirect_pc = rpc;
    out_ready = ($urandom_range(0, 99) < ready_pct);
    req_ready = ($urandom_range(0, 3) != 0);
    #1;
    if (warm)
      check("req_valid", req_valid, !halted && !pending && exp_q.size() < DEPTH && !redir);
    pop = out_valid && out_ready && !redir;
    if (pop) begin
      n_pops++;
      check("pop_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e[97:34]);
        check("out_inst", out_inst, e[33:2]);
        check("out_jal", out_jal, e[1]);
        check("out_fault", out_fault, e[0]);
        if (out_fault) got_fault = 1;
      end
    end
    fire = req_valid && req_ready;
    if (fire) begin
      check("req_addr", req_addr, {fpc[63:3], 3'b000});
      if (first_fire) check("first_req_addr", req_addr, RESET_PC);
      first_fire = 0;
    end
    if (deliver) pending = 0;
    if (redir) begin
      n_redir++;
      exp_q.delete();
      stale = pending;
      fpc = rpc;
      halted = 0;
      if (rpc[1:0] != 2'b00) begin
        exp_q.push_back({rpc, 32'h0, 1'b0, 1'b1});
        halted = 1;
      end
    end else if (deliver && !stale) begin
      fill_word({fpc[63:3], 3'b000});
      w = mem[{fpc[63:3], 3'b000}];
      inst = fpc[2] ? w[63:32] : w[31:0];
      is_jal = jal_tab.exists(fpc);
      exp_q.push_back({fpc, inst, is_jal, 1'b0});
      npc = is_jal ? fpc + 64'(jal_tab[fpc]) : fpc + 64'd4;
      fpc = npc;
      if (npc[1:0] != 2'b00) begin
        exp_q.push_back({npc, 32'h0, 1'b0, 1'b1});
        halted = 1;
      end
    end
    if (deliver) stale = 0;
    if (fire) begin
      pending = 1;
      stale = 0;
      wait_cnt = $urandom_range(lat_min, lat_max);
      pend_addr = {req_addr[63:3], 3'b000};
    end
    warm = 1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_pc"}, out_pc, 0);
    check({tag, "_out_inst"}, out_inst, 0);
    check({tag, "_out_jal"}, out_jal, 0);
    check({tag, "_out_fault"}, out_fault, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    model_reset();
    set_slot(64'h8000_0000, 0, 0);
    set_slot(64'h8000_0004, 0, 0);
    set_slot(64'h8000_0008, 1, 8);
    set_slot(64'h8000_0010, 1, -4);
    set_slot(64'h8000_000C, 1, -12);
    for (int i = 0; i < 32; i++) set_slot(64'h8000_2000 + 64'(i * 4), 0, 0);
    #1;
    check_outputs_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1-cycle memory, plain words then the JAL loop
    lat_min = 1; lat_max = 1; ready_pct = 100;
    for (int i = 0; i < 30; i++) step(0, '0);

    // redirect while waiting on a 3-cycle response
    lat_min = 3; lat_max = 3;
    r0 = n_redir;
    for (int i = 0; i < 20 && n_redir == r0; i++) step(3, 64'h8000_1000);
    check("redir_wait_hit", n_redir - r0, 1);
    for (int i = 0; i < 20; i++) step(0, '0);

    // redirect on the same cycle as the response
    lat_min = 2; lat_max = 2;
    r0 = n_redir;
    for (int i = 0; i < 20 && n_redir == r0; i++) step(2, 64'h8000_0100);
    check("redir_resp_hit", n_redir - r0, 1);
    for (int i = 0; i < 20; i++) step(0, '0);

    // misaligned redirect parks the engine until the next redirect
    got_fault = 0;
    step(4, 64'h8000_0002);
    for (int i = 0; i < 10; i++) step(0, '0);
    check("fault_seen", got_fault, 1);
    step(4, 64'h8000_0100);
    for (int i = 0; i < 20; i++) step(0, '0);

    // back-pressure into a JAL-free region
    lat_min = 1; lat_max = 1;
    step(4, 64'h8000_2000);
    ready_pct = 0;
    for (int i = 0; i < 30; i++) step(0, '0);
    check("bp_out_valid", out_valid, 1);
    check("bp_req_blocked", req_valid, 0);
    ready_pct = 100; step(0, '0);
    ready_pct = 0;
    for (int i = 0; i < 8; i++) step(0, '0);
    ready_pct = 100;
    for (int i = 0; i < 20; i++) step(0, '0);

    // random traffic
    lat_min = 1; lat_max = 3; ready_pct = 60;
    for (int i = 0; i < 3000; i++) step(1, '0);

    // reset asserted while a request is outstanding
    for (int i = 0; i < 50 && !pending; i++) step(0, '0);
    check("reached_wait", pending, 1);
    @(negedge clk);
    resp_valid = 0; redirect_valid = 0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) step(1, '0);

    check("progress", n_pops > 200, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
